// File: rtl/seven_seg_scan_n.sv
// Time-multiplexed N-digit seven-segment driver with double-buffered BCD frame and leading-zero blanking.
// Optional macro SEG_HEX_EN: show hex glyphs A..F for nibbles 10..15 (otherwise segments a..g stay dark).
module seven_seg_scan_n #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 100000,
  parameter int BLANK_LEAD = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    load,
  input  logic                    enable,
  output logic [7:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_tick
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_dig_q, disp_dig_q;
  logic [NUM_DIGITS-1:0]   pend_dp_q, disp_dp_q;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    tick_q, tick_d;

  logic                    presc_wrap, idx_last, commit;
  logic [3:0]              cur_nib;
  logic                    cur_dp, cur_blank;
  logic [NUM_DIGITS-1:0]   blank_mask;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h67;
`ifdef SEG_HEX_EN
      4'd10:   glyph = 7'h77;
      4'd11:   glyph = 7'h7C;
      4'd12:   glyph = 7'h39;
      4'd13:   glyph = 7'h5E;
      4'd14:   glyph = 7'h79;
      4'd15:   glyph = 7'h71;
`else
      4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15: glyph = 7'h00;
`endif
      default: glyph = 7'h00;
    endcase
  endfunction

  // A digit is blanked only while it and everything to its left is a zero nibble with no dp.
  function automatic logic [NUM_DIGITS-1:0] lead_blank(input logic [4*NUM_DIGITS-1:0] nib,
                                                       input logic [NUM_DIGITS-1:0]   pts);
    logic run;
    lead_blank = '0;
    run        = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      run           = run && (nib[4*i +: 4] == 4'd0) && !pts[i];
      lead_blank[i] = run;
    end
  endfunction

  always_comb begin
    presc_wrap = (presc_q == PW'(SCAN_DIV - 1));
    idx_last   = (idx_q == IW'(NUM_DIGITS - 1));
    commit     = presc_wrap && idx_last;
    presc_d    = presc_wrap ? '0 : presc_q + 1'b1;
    idx_d      = idx_q;
    if (presc_wrap) begin
      idx_d = idx_last ? '0 : idx_q + 1'b1;
    end
    tick_d = commit;
  end

  always_comb begin
    blank_mask = (BLANK_LEAD != 0) ? lead_blank(disp_dig_q, disp_dp_q) : '0;
    cur_nib    = 4'd0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        cur_nib   = disp_dig_q[4*k +: 4];
        cur_dp    = disp_dp_q[k];
        cur_blank = blank_mask[k];
      end
    end
  end

  // Slot position 0 is the anti-ghost dead cycle: nothing lit while the anode changes.
  always_comb begin
    seg_d = 8'hFF;
    an_d  = '1;
    if (enable && (presc_q != '0)) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        an_d[k] = (idx_q != IW'(k));
      end
      if (!cur_blank) begin
        seg_d = ~{cur_dp, glyph(cur_nib)};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      idx_q      <= '0;
      pend_dig_q <= '0;
      pend_dp_q  <= '0;
      disp_dig_q <= '0;
      disp_dp_q  <= '0;
      seg_q      <= 8'hFF;
      an_q       <= '1;
      tick_q     <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      tick_q  <= tick_d;
      if (load) begin
        pend_dig_q <= digits;
        pend_dp_q  <= dp;
      end
      // Commit takes the pending value held before this edge; a same-edge load waits a frame.
      if (commit) begin
        disp_dig_q <= pend_dig_q;
        disp_dp_q  <= pend_dp_q;
      end
    end
  end

  assign seg_n      = seg_q;
  assign an_n       = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seven_seg_scan_n.sv
// Directed bench for seven_seg_scan_n with NUM_DIGITS=4, SCAN_DIV=4, BLANK_LEAD=1.
module tb_seven_seg_scan_n;

  logic        clk;
  logic        rst_n;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic        load;
  logic        enable;
  logic [7:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame_tick;

  int vectors;
  int miscompares;

  seven_seg_scan_n #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_LEAD(1)) dut (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp(dp), .load(load), .enable(enable),
    .seg_n(seg_n), .an_n(an_n), .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (frame_tick === 1'b1) seen = 1'b1;
    end
    chk("wait_tick_timeout", {7'd0, seen}, 8'd1);
  endtask

  // Entered on a frame_tick cycle; walks the 16 cycles of one frame, optionally injecting a load.
  task automatic check_frame(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                             input logic [7:0] s3, input int load_at,
                             input logic [15:0] ld_dig, input logic [3:0] ld_dp);
    logic [7:0] es[4];
    logic [3:0] an_exp;
    int slot, pos;
    es = '{s0, s1, s2, s3};
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c == load_at + 1) load = 1'b0;
      slot = (c - 1) / 4;
      pos  = (c - 1) % 4;
      if (pos == 0) begin
        chk($sformatf("dead_an c%0d", c), {4'd0, an_n}, 8'h0F);
        chk($sformatf("dead_seg c%0d", c), seg_n, 8'hFF);
      end else begin
        an_exp = ~(4'b0001 << slot);
        chk($sformatf("an c%0d", c), {4'd0, an_n}, {4'd0, an_exp});
        chk($sformatf("seg slot%0d c%0d", slot, c), seg_n, es[slot]);
      end
      chk($sformatf("tick c%0d", c), {7'd0, frame_tick}, (c == 16) ? 8'd1 : 8'd0);
      if (c == load_at) begin
        load   = 1'b1;
        digits = ld_dig;
        dp     = ld_dp;
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n  = 1'b1;
    digits = 16'h0;
    dp     = 4'h0;
    load   = 1'b0;
    enable = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_seg", seg_n, 8'hFF);
    chk("rst_an", {4'd0, an_n}, 8'h0F);
    chk("rst_tick", {7'd0, frame_tick}, 8'd0);
    step();
    step();
    rst_n = 1'b1;

    // 1234 loaded and shown from the next frame
    digits = 16'h1234;
    dp     = 4'h0;
    load   = 1'b1;
    step();
    load = 1'b0;
    wait_tick();
    check_frame(8'h99, 8'hB0, 8'hA4, 8'hF9, 5, 16'h5678, 4'h0);
    // mid-frame load held off until the commit; then a load on the commit edge waits a frame
    check_frame(8'h80, 8'hF8, 8'h82, 8'h92, 15, 16'h9012, 4'h0);
    check_frame(8'h80, 8'hF8, 8'h82, 8'h92, -1, 16'h0, 4'h0);
    check_frame(8'hA4, 8'hF9, 8'hC0, 8'h98, 3, 16'h0007, 4'h0);
    // leading-zero blanking, dp holds a zero digit lit
    check_frame(8'hF8, 8'hFF, 8'hFF, 8'hFF, 3, 16'h0005, 4'b0100);
    check_frame(8'h92, 8'hC0, 8'h40, 8'hFF, 3, 16'h00AF, 4'h0);
`ifdef SEG_HEX_EN
    check_frame(8'h8E, 8'h88, 8'hFF, 8'hFF, 3, 16'h1234, 4'h0);
`else
    check_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 3, 16'h1234, 4'h0);
`endif

    // enable off mid-slot: dark next cycle, frame_tick keeps its period
    for (int c = 1; c <= 6; c++) step();
    chk("en_pre_an", {4'd0, an_n}, 8'h0D);
    chk("en_pre_seg", seg_n, 8'hB0);
    enable = 1'b0;
    step();
    chk("en_off_an", {4'd0, an_n}, 8'h0F);
    chk("en_off_seg", seg_n, 8'hFF);
    for (int c = 8; c <= 16; c++) step();
    chk("en_off_tick", {7'd0, frame_tick}, 8'd1);
    chk("en_off_seg16", seg_n, 8'hFF);
    for (int c = 1; c <= 9; c++) step();
    chk("en_off_an9", {4'd0, an_n}, 8'h0F);
    enable = 1'b1;
    step();
    chk("en_on_an", {4'd0, an_n}, 8'h0B);
    chk("en_on_seg", seg_n, 8'hA4);

    // pending load lost on async reset mid-scan; outputs blank without a clock edge
    digits = 16'h5678;
    load   = 1'b1;
    step();
    load = 1'b0;
    step();
    chk("pre_rst_an", {4'd0, an_n}, 8'h0B);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_seg", seg_n, 8'hFF);
    chk("mid_rst_an", {4'd0, an_n}, 8'h0F);
    chk("mid_rst_tick", {7'd0, frame_tick}, 8'd0);
    step();
    step();
    rst_n = 1'b1;
    wait_tick();
    check_frame(8'hC0, 8'hFF, 8'hFF, 8'hFF, -1, 16'h0, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
